keypad_scan_ctrl: RTL and testbench

- Controller for a ROWS x COLS matrix keypad built from the team's debounce technique: synchronize inputs, then require a stable-count window.
- Drives one column low at a time, waits for the lines to settle, samples the rows, then debounces a detected key with one shared counter.
- Presents the key code on a valid/ready interface and tracks release before scanning resumes.
- Sits between the board keypad pins and the system's command/input logic.

---
 rtl/keypad_pkg.sv | 36 +++
 rtl/sync_2ff.sv | 25 ++
 rtl/keypad_scan_ctrl.sv | 162 ++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared state encoding, width helpers and column decode for the keypad scanner
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } kp_state_t;

  localparam int DEF_ROWS     = 4;
  localparam int DEF_COLS     = 4;
  localparam int DEF_SETTLE   = 4;
  localparam int DEF_DEBOUNCE = 16;

  // Key index width; never collapses to zero bits for a 1x1 pad.
  function automatic int code_width(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

  // One counter serves both the settle and the debounce windows, so it is
  // sized for the larger of the two plus one bit of headroom.
  function automatic int cnt_width(input int settle, input int deb);
    int m;
    m = (settle > deb) ? settle : deb;
    return $clog2(m) + 1;
  endfunction

  localparam int CODE_W = code_width(DEF_ROWS, DEF_COLS);
  localparam int CNT_W  = cnt_width(DEF_SETTLE, DEF_DEBOUNCE);

  // One-hot select of a column index; callers truncate to their column count.
  function automatic logic [31:0] col_onehot(input int idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - parameterized-width two-flop synchronizer with async active-low reset
module sync_2ff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two back-to-back flops per bit to resolve metastability from the pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - matrix keypad column scanner with shared debounce counter and key event output
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int ROWS          = 4,
  parameter int COLS          = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int DEBOUNCE_MAX  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ROWS-1:0]               row_in,
  output logic [COLS-1:0]               col_out,
  output logic                          key_valid,
  output logic [$clog2(ROWS*COLS)-1:0]  key_code,
  input  logic                          key_ready,
  output logic                          key_held,
  output logic                          overrun
);

  localparam int CNTW  = cnt_width(SETTLE_CYCLES, DEBOUNCE_MAX);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int KCW   = $clog2(ROWS * COLS);

  kp_state_t  state_q, state_d;
  logic [COL_W-1:0] col_q, col_d, col_next;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [ROW_W-1:0] cap_row_q, cap_row_d, low_row;
  logic [COL_W-1:0] cap_col_q, cap_col_d;
  logic [ROWS-1:0]  row_s;
  logic             started_q;
  logic             any_active;
  logic             cap_match;
  logic             press;
  logic [KCW-1:0]   new_code;

  sync_2ff #(
    .W       (ROWS),
    .RST_VAL ({ROWS{1'b1}})
  ) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row_in),
    .q     (row_s)
  );

  // Lowest active row and whether the captured key pattern still holds.
  always_comb begin
    any_active = ~&row_s;
    low_row    = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (!row_s[r]) low_row = ROW_W'(r);
    end
    cap_match = !row_s[cap_row_q];
    for (int r = 0; r < ROWS; r++) begin
      if (r < int'(cap_row_q) && !row_s[r]) cap_match = 1'b0;
    end
  end

  // Next-state logic: settle/sample in SCAN, stable-window checks in DEBOUNCE and HELD.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    cnt_d     = cnt_q;
    cap_row_d = cap_row_q;
    cap_col_d = cap_col_q;
    press     = 1'b0;
    col_next  = (col_q == COL_W'(COLS - 1)) ? '0 : col_q + 1'b1;
    new_code  = KCW'(int'(cap_row_q) * COLS + int'(cap_col_q));
    if (started_q) begin
      case (state_q)
        SCAN: begin
          if (cnt_q == CNTW'(SETTLE_CYCLES - 1)) begin
            cnt_d = '0;
            if (any_active) begin
              state_d   = DEBOUNCE;
              cap_row_d = low_row;
              cap_col_d = col_q;
            end else begin
              col_d = col_next;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (!cap_match) begin
            state_d = SCAN;
            cnt_d   = '0;
          end else if (cnt_q == CNTW'(DEBOUNCE_MAX - 1)) begin
            state_d = HELD;
            cnt_d   = '0;
            press   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HELD: begin
          if (!row_s[cap_row_q]) begin
            cnt_d = '0;
          end else if (cnt_q == CNTW'(DEBOUNCE_MAX - 1)) begin
            state_d = SCAN;
            cnt_d   = '0;
            col_d   = col_next;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = SCAN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter, capture and column drive registers; the first cycle out of reset only enables the drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SCAN;
      col_q     <= '0;
      cnt_q     <= '0;
      cap_row_q <= '0;
      cap_col_q <= '0;
      started_q <= 1'b0;
      col_out   <= '1;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      cnt_q     <= cnt_d;
      cap_row_q <= cap_row_d;
      cap_col_q <= cap_col_d;
      started_q <= 1'b1;
      col_out   <= ~COLS'(col_onehot(int'(col_d)));
    end
  end

  // Event register: a press loads only if the slot is empty or being accepted, otherwise flags overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (press) begin
        if (!key_valid || key_ready) begin
          key_valid <= 1'b1;
          key_code  <= new_code;
        end else begin
          overrun <= 1'b1;
        end
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

  assign key_held = (state_q == HELD);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - directed, table-driven bench for keypad_scan_ctrl
module tb_keypad_scan_ctrl;
  import keypad_pkg::*;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef struct {
    logic [3:0] exp_col;
    int         cycles;
  } scan_vec_t;

  typedef struct {
    int         row;
    int         col;
    logic [3:0] exp_code;
  } key_vec_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ROWS-1:0]   row_in;
  logic [COLS-1:0]   col_out;
  logic              key_valid;
  logic [CODE_W-1:0] key_code;
  logic              key_ready;
  logic              key_held;
  logic              overrun;
  logic [15:0]       keys;

  int total = 0;
  int bad   = 0;

  scan_vec_t sv[5];
  key_vec_t  kv[5];

  keypad_scan_ctrl #(
    .ROWS          (ROWS),
    .COLS          (COLS),
    .SETTLE_CYCLES (4),
    .DEBOUNCE_MAX  (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .key_held  (key_held),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_in = '1;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (keys[r*COLS+c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic logic [3:0] drv(input int c);
    logic [3:0] v;
    v    = 4'b1111;
    v[c] = 1'b0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_col(input int c);
    int n;
    n = 0;
    while (col_out !== drv(c) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("col_reached", 32'(col_out), 32'(drv(c)));
  endtask

  // Returns at the negedge where key_valid is due: settle (4) + debounce (16) after the column turns on.
  task automatic press_to_accept(input int r, input int c, input logic exp_valid_before);
    wait_col((c + COLS - 1) % COLS);
    keys[r*COLS+c] = 1'b1;
    wait_col(c);
    repeat (19) @(negedge clk);
    check("held_before_accept", 32'(key_held), 32'd0);
    check("valid_before_accept", 32'(key_valid), 32'(exp_valid_before));
    @(negedge clk);
  endtask

  // Release: 2 sync cycles then 16 clean cycles before key_held drops and scan moves on.
  task automatic release_to_idle(input int r, input int c);
    keys[r*COLS+c] = 1'b0;
    repeat (17) @(negedge clk);
    check("held_before_release", 32'(key_held), 32'd1);
    @(negedge clk);
    check("held_after_release", 32'(key_held), 32'd0);
    check("col_after_release", 32'(col_out), 32'(drv((c + 1) % COLS)));
  endtask

  initial begin
    logic saw_valid;
    logic saw_held;
    logic prev_valid;
    int   n_ev;
    int   n;

    sv[0] = '{4'b1110, 4};
    sv[1] = '{4'b1101, 4};
    sv[2] = '{4'b1011, 4};
    sv[3] = '{4'b0111, 4};
    sv[4] = '{4'b1110, 4};

    kv[0] = '{2, 1, 4'd9};
    kv[1] = '{0, 0, 4'd0};
    kv[2] = '{3, 3, 4'd15};
    kv[3] = '{1, 2, 4'd6};
    kv[4] = '{0, 3, 4'd3};

    keys      = '0;
    key_ready = 1'b0;
    rst_n     = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_col_out", 32'(col_out), 32'hF);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_code", 32'(key_code), 32'd0);
    check("rst_held", 32'(key_held), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < sv[i].cycles; k++) begin
        @(negedge clk);
        check($sformatf("idle_col_%0d_%0d", i, k), 32'(col_out), 32'(sv[i].exp_col));
        check("idle_no_valid", 32'(key_valid), 32'd0);
      end
    end

    key_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      press_to_accept(kv[i].row, kv[i].col, 1'b0);
      check($sformatf("key%0d_valid", i), 32'(key_valid), 32'd1);
      check($sformatf("key%0d_code", i), 32'(key_code), 32'(kv[i].exp_code));
      check($sformatf("key%0d_held", i), 32'(key_held), 32'd1);
      check($sformatf("key%0d_overrun", i), 32'(overrun), 32'd0);
      @(negedge clk);
      check($sformatf("key%0d_valid_after_hs", i), 32'(key_valid), 32'd0);
      release_to_idle(kv[i].row, kv[i].col);
    end

    wait_col(1);
    keys[2] = 1'b1;
    wait_col(2);
    repeat (4) @(negedge clk);
    saw_valid = 1'b0;
    saw_held  = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i % 5 == 0) keys[2] = ~keys[2];
      saw_valid |= key_valid;
      saw_held  |= key_held;
    end
    check("bounce_no_valid", 32'(saw_valid), 32'd0);
    check("bounce_no_held", 32'(saw_held), 32'd0);
    keys[2]    = 1'b1;
    n_ev       = 0;
    prev_valid = key_valid;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (key_valid && !prev_valid) begin
        n_ev++;
        check("stable_code", 32'(key_code), 32'd2);
      end
      prev_valid = key_valid;
    end
    check("stable_one_event", 32'(n_ev), 32'd1);
    keys[2] = 1'b0;
    n = 0;
    while (key_held && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("stable_released", 32'(key_held), 32'd0);

    key_ready = 1'b0;
    press_to_accept(1, 1, 1'b0);
    check("bp_first_valid", 32'(key_valid), 32'd1);
    check("bp_first_code", 32'(key_code), 32'd5);
    check("bp_first_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    check("bp_valid_holds", 32'(key_valid), 32'd1);
    release_to_idle(1, 1);
    check("bp_valid_after_release", 32'(key_valid), 32'd1);
    press_to_accept(2, 2, 1'b1);
    check("bp_overrun_pulse", 32'(overrun), 32'd1);
    check("bp_code_kept", 32'(key_code), 32'd5);
    check("bp_second_held", 32'(key_held), 32'd1);
    @(negedge clk);
    check("bp_overrun_clear", 32'(overrun), 32'd0);
    check("bp_code_still", 32'(key_code), 32'd5);
    key_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_cleared", 32'(key_valid), 32'd0);
    release_to_idle(2, 2);

    wait_col(0);
    keys[13] = 1'b1;
    wait_col(1);
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_col", 32'(col_out), 32'hF);
    check("async_rst_valid", 32'(key_valid), 32'd0);
    check("async_rst_held", 32'(key_held), 32'd0);
    check("async_rst_code", 32'(key_code), 32'd0);
    keys = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_col0", 32'(col_out), 32'hE);
    saw_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      saw_valid |= key_valid | key_held;
    end
    check("post_rst_no_event", 32'(saw_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
